// File: rtl/writeback_unit_if.sv
// Writeback unit bus: issue-side instruction info, ALU result registers,
// register-file read ports, fetch redirect and the retire counter.
interface writeback_if #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 5
);
    localparam int RD_W = $clog2(NUM_REGS);

    logic               issue_en;
    logic [INSTR_W-1:0] issue_instr;
    logic [RD_W-1:0]    issue_rd;
    logic [ADDR_W-1:0]  issue_pc;
    logic [DATA_W-1:0]  issue_imm;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_eq;

    logic [RD_W-1:0]    rs1_addr;
    logic [RD_W-1:0]    rs2_addr;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [31:0]        retire_count;

    // Issue/ALU side drives instructions and results, observes the unit.
    modport master (
        output issue_en, issue_instr, issue_rd, issue_pc, issue_imm,
        output alu_result, alu_eq, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, redirect, redirect_pc, retire_count
    );

    // The writeback unit itself.
    modport slave (
        input  issue_en, issue_instr, issue_rd, issue_pc, issue_imm,
        input  alu_result, alu_eq, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, redirect, redirect_pc, retire_count
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: holds the one-deep issue->commit pipeline register, owns the
// architectural register file, resolves jumps/branches into a fetch redirect,
// squashes the wrong-path instruction issued alongside a redirect, and counts
// committed instructions.
//
// Opcode encoding: ADD=0 SUB=1 MUL=2 DIV=3 ABS=4 SLT=5 SGT=6 SEQ=7 SNEZ=8
// MIN=9 ADDI=10 MULI=11 DIVI=12 SLLI=13 JAL=14 BEQZ=15; anything else commits
// without side effects.
module writeback_unit #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 5
) (
    input  logic     clk,
    input  logic     reset,
    writeback_if.slave bus
);
    localparam int RD_W = $clog2(NUM_REGS);

    localparam logic [INSTR_W-1:0] OP_SLLI = INSTR_W'(13);
    localparam logic [INSTR_W-1:0] OP_JAL  = INSTR_W'(14);
    localparam logic [INSTR_W-1:0] OP_BEQZ = INSTR_W'(15);

    // Pipeline register P
    logic               p_valid_q, p_valid_d;
    logic [INSTR_W-1:0] p_instr_q, p_instr_d;
    logic [RD_W-1:0]    p_rd_q,    p_rd_d;
    logic [ADDR_W-1:0]  p_pc_q,    p_pc_d;
    logic [DATA_W-1:0]  p_imm_q,   p_imm_d;

    // Architectural state
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];
    logic [31:0]        retire_q, retire_d;

    // Commit-cycle decode
    logic               is_alu_write;
    logic               is_jal;
    logic               is_beqz;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic [ADDR_W-1:0]  pc_plus_one;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    // Decode the instruction in P against this cycle's ALU outputs.
    always_comb begin
        is_alu_write = 1'b0;
        is_jal       = 1'b0;
        is_beqz      = 1'b0;
        wr_en        = 1'b0;
        wr_data      = bus.alu_result;
        pc_plus_one  = p_pc_q + ADDR_W'(1);
        redirect     = 1'b0;
        redirect_pc  = '0;
        if (p_valid_q) begin
            is_alu_write = (p_instr_q <= OP_SLLI);
            is_jal       = (p_instr_q == OP_JAL);
            is_beqz      = (p_instr_q == OP_BEQZ);
            wr_en        = (is_alu_write || is_jal) && (p_rd_q != '0);
            if (is_jal) begin
                wr_data     = DATA_W'(pc_plus_one);
                redirect    = 1'b1;
                redirect_pc = ADDR_W'(bus.alu_result);
            end else if (is_beqz && bus.alu_eq) begin
                redirect    = 1'b1;
                redirect_pc = ADDR_W'(DATA_W'(p_pc_q) + p_imm_q);
            end
        end
    end

    // Next state: load P unless a redirect squashes the co-issued instruction,
    // apply the register write, and count the commit.
    always_comb begin
        p_valid_d = bus.issue_en && !redirect;
        p_instr_d = p_instr_q;
        p_rd_d    = p_rd_q;
        p_pc_d    = p_pc_q;
        p_imm_d   = p_imm_q;
        if (bus.issue_en) begin
            p_instr_d = bus.issue_instr;
            p_rd_d    = bus.issue_rd;
            p_pc_d    = bus.issue_pc;
            p_imm_d   = bus.issue_imm;
        end
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[p_rd_q] = wr_data;
        end
        regs_d[0] = '0;
        retire_d  = retire_q + {31'd0, p_valid_q};
    end

    // State registers; reset aborts any in-flight commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_valid_q <= 1'b0;
            p_instr_q <= '0;
            p_rd_q    <= '0;
            p_pc_q    <= '0;
            p_imm_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            retire_q  <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_instr_q <= p_instr_d;
            p_rd_q    <= p_rd_d;
            p_pc_q    <= p_pc_d;
            p_imm_q   <= p_imm_d;
            regs_q    <= regs_d;
            retire_q  <= retire_d;
        end
    end

    // Read port 1 with same-cycle bypass of the committing write.
    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_addr != '0) begin
            if (wr_en && (bus.rs1_addr == p_rd_q)) begin
                bus.rs1_data = wr_data;
            end else begin
                bus.rs1_data = regs_q[bus.rs1_addr];
            end
        end
    end

    // Read port 2 with same-cycle bypass of the committing write.
    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_addr != '0) begin
            if (wr_en && (bus.rs2_addr == p_rd_q)) begin
                bus.rs2_data = wr_data;
            end else begin
                bus.rs2_data = regs_q[bus.rs2_addr];
            end
        end
    end

    // Redirect and retire outputs.
    always_comb begin
        bus.redirect     = redirect;
        bus.redirect_pc  = redirect_pc;
        bus.retire_count = retire_q;
    end
endmodule
